// File: rtl/scan_sequencer_if.sv
// Host/readout-facing bundle of the raster scan sequencer.
// The timeout flag exists only when SCAN_TIMEOUT_EN is defined.
interface scan_sequencer_if;
    logic       start;
    logic       abort;
    logic       mode_rev;
    logic       stride2;
    logic       row_ovf;
    logic       col_ovf;
    logic       sample_ack;
    logic [4:0] row_ctrl;
    logic [4:0] col_ctrl;
    logic       sample;
    logic       busy;
    logic       done;
`ifdef SCAN_TIMEOUT_EN
    logic       timeout;

    modport master (
        output start, abort, mode_rev, stride2, row_ovf, col_ovf, sample_ack,
        input  row_ctrl, col_ctrl, sample, busy, done, timeout
    );
    modport slave (
        input  start, abort, mode_rev, stride2, row_ovf, col_ovf, sample_ack,
        output row_ctrl, col_ctrl, sample, busy, done, timeout
    );
`else
    modport master (
        output start, abort, mode_rev, stride2, row_ovf, col_ovf, sample_ack,
        input  row_ctrl, col_ctrl, sample, busy, done
    );
    modport slave (
        input  start, abort, mode_rev, stride2, row_ovf, col_ovf, sample_ack,
        output row_ctrl, col_ctrl, sample, busy, done
    );
`endif
endinterface

// File: rtl/scan_sequencer.sv
// Raster-scan sequencer driving a row/column pair of offset counters.
// Define SCAN_TIMEOUT_EN to add a sample_ack watchdog with a sticky timeout flag.
module scan_sequencer #(
    parameter int MOD_ROW        = 24,
    parameter int MOD_COL        = 24,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    scan_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SETTLE,
        S_SAMPLE,
        S_STEP,
        S_DONE
    } state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam state_t PIX_ENTRY = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

    // The counters are 5 bits wide, so a modulus above 32 cannot be addressed.
    if (MOD_ROW < 1 || MOD_ROW > 32 || MOD_COL < 1 || MOD_COL > 32 ||
        SETTLE_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("scan_sequencer: parameter out of range");
    end

    state_t        state_q, state_d;
    logic          rev_q, rev_d;
    logic          s2_q, s2_d;
    logic          clr_q, clr_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [2:0]    step_sel;

`ifdef SCAN_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] to_q, to_d;
    logic          timeout_q, timeout_d;

    assign bus.timeout = timeout_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rev_q     <= 1'b0;
            s2_q      <= 1'b0;
            clr_q     <= 1'b0;
            settle_q  <= '0;
`ifdef SCAN_TIMEOUT_EN
            to_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rev_q     <= rev_d;
            s2_q      <= s2_d;
            clr_q     <= clr_d;
            settle_q  <= settle_d;
`ifdef SCAN_TIMEOUT_EN
            to_q      <= to_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign step_sel = rev_q ? 3'b111 : (s2_q ? 3'b110 : 3'b101);

    always_comb begin
        state_d      = state_q;
        rev_d        = rev_q;
        s2_d         = s2_q;
        clr_d        = 1'b0;
        settle_d     = '0;
        bus.row_ctrl = 5'b00000;
        bus.col_ctrl = 5'b00000;
        bus.sample   = 1'b0;
        bus.busy     = (state_q != S_IDLE);
        bus.done     = 1'b0;
`ifdef SCAN_TIMEOUT_EN
        to_d         = '0;
        timeout_d    = timeout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // clr_q marks the first idle cycle after an abort: clear both counters.
                if (clr_q) begin
                    bus.row_ctrl = 5'b10000;
                    bus.col_ctrl = 5'b10000;
                end
                if (bus.start) begin
                    rev_d   = bus.mode_rev;
                    s2_d    = bus.stride2;
                    state_d = S_INIT;
`ifdef SCAN_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            S_INIT: begin
                bus.row_ctrl = rev_q ? 5'b01000 : 5'b10000;
                bus.col_ctrl = rev_q ? 5'b01000 : 5'b10000;
                state_d      = PIX_ENTRY;
            end
            S_SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_SAMPLE: begin
                bus.sample = 1'b1;
                if (bus.sample_ack) begin
                    state_d = S_STEP;
`ifdef SCAN_TIMEOUT_EN
                end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_STEP;
                    timeout_d = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
`endif
                end
            end
            S_STEP: begin
                // Row enable is gated by col_ovf; each counter's overflow depends
                // only on its own enable/step bits, so no combinational loop forms.
                bus.col_ctrl[2:0] = step_sel;
                state_d           = PIX_ENTRY;
                if (bus.col_ovf) begin
                    bus.col_ctrl[4:3] = rev_q ? 2'b01 : 2'b10;
                    bus.row_ctrl[2:0] = rev_q ? 3'b111 : 3'b101;
                    if (bus.row_ovf) begin
                        bus.row_ctrl[4:3] = rev_q ? 2'b01 : 2'b10;
                        state_d           = S_DONE;
                    end
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            clr_d   = 1'b1;
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer with behavioural offset-counter models.
// Two instances: A (3x4, settle 2, timeout 8) and B (3x5, settle 0).
module tb_scan_sequencer;

    localparam int MR   = 3;
    localparam int MC_A = 4;
    localparam int MC_B = 5;

    typedef struct {
        string      name;
        int         sel;
        bit         rev;
        bit         s2;
        bit         skip;
        logic [4:0] exp_init;
        int         exp_count;
        int         exp_gap;
    } frame_vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scan_sequencer_if if_a();
    scan_sequencer_if if_b();

    scan_sequencer #(.MOD_ROW(MR), .MOD_COL(MC_A), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(8))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    scan_sequencer #(.MOD_ROW(MR), .MOD_COL(MC_B), .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(255))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    logic [1:0] start_v, abort_v, rev_v, s2_v, ack_en, ack_force;
    logic       skip_en;
    logic [4:0] rcnt [2];
    logic [4:0] ccnt [2];
    logic [5:0] reval[2];
    logic [5:0] ceval[2];
    logic [1:0] smp, bsy, dn, ackv;
    logic [4:0] rctl [2];
    logic [4:0] cctl [2];
    logic [4:0] rowv [2];
    logic [4:0] colv [2];

    int n_pass  = 0;
    int n_total = 0;

    // Offset counter model: {overflow, combinational value}; priority reset > load-max > enable.
    function automatic logic [5:0] cnt_eval(input logic [4:0] ctrl, input logic [4:0] cnt, input int md);
        int         nxt;
        logic       ovf;
        logic [4:0] val;
        ovf = 1'b0;
        val = cnt;
        nxt = int'(cnt);
        if (ctrl[2]) begin
            case (ctrl[1:0])
                2'b01:   nxt = int'(cnt) + 1;
                2'b10:   nxt = int'(cnt) + 2;
                2'b11:   nxt = int'(cnt) - 1;
                default: nxt = int'(cnt);
            endcase
            if (nxt >= md) begin
                ovf = 1'b1;
                val = 5'(nxt - md);
            end else if (nxt < 0) begin
                ovf = 1'b1;
                val = 5'(md - 1);
            end else begin
                val = 5'(nxt);
            end
        end
        if (ctrl[3]) val = 5'(md - 1);
        if (ctrl[4]) val = 5'd0;
        return {ovf, val};
    endfunction

    assign if_a.start    = start_v[0];
    assign if_a.abort    = abort_v[0];
    assign if_a.mode_rev = rev_v[0];
    assign if_a.stride2  = s2_v[0];
    assign if_b.start    = start_v[1];
    assign if_b.abort    = abort_v[1];
    assign if_b.mode_rev = rev_v[1];
    assign if_b.stride2  = s2_v[1];

    assign reval[0] = cnt_eval(if_a.row_ctrl, rcnt[0], MR);
    assign ceval[0] = cnt_eval(if_a.col_ctrl, ccnt[0], MC_A);
    assign reval[1] = cnt_eval(if_b.row_ctrl, rcnt[1], MR);
    assign ceval[1] = cnt_eval(if_b.col_ctrl, ccnt[1], MC_B);

    assign if_a.row_ovf = reval[0][5];
    assign if_a.col_ovf = ceval[0][5];
    assign if_b.row_ovf = reval[1][5];
    assign if_b.col_ovf = ceval[1][5];

    assign if_a.sample_ack = (ack_en[0] & if_a.sample &
                              ~(skip_en & (reval[0][4:0] == 5'd1) & (ceval[0][4:0] == 5'd1))) | ack_force[0];
    assign if_b.sample_ack = (ack_en[1] & if_b.sample) | ack_force[1];

    assign smp  = {if_b.sample, if_a.sample};
    assign bsy  = {if_b.busy, if_a.busy};
    assign dn   = {if_b.done, if_a.done};
    assign ackv = {if_b.sample_ack, if_a.sample_ack};
    assign rctl[0] = if_a.row_ctrl;
    assign rctl[1] = if_b.row_ctrl;
    assign cctl[0] = if_a.col_ctrl;
    assign cctl[1] = if_b.col_ctrl;
    assign rowv[0] = reval[0][4:0];
    assign rowv[1] = reval[1][4:0];
    assign colv[0] = ceval[0][4:0];
    assign colv[1] = ceval[1][4:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rcnt[i] <= 5'd0;
                ccnt[i] <= 5'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rcnt[i] <= reval[i][4:0];
                ccnt[i] <= ceval[i][4:0];
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input int sel, input bit rev, input bit s2);
        @(negedge clk);
        start_v[sel] = 1'b1;
        rev_v[sel]   = rev;
        s2_v[sel]    = s2;
        @(negedge clk);
        start_v[sel] = 1'b0;
    endtask

    task automatic run_frame(input frame_vec_t v);
        int exp_r[$];
        int exp_c[$];
        int mc, idx, last_ack, stride;
        bit got_done, busy_dropped;
        mc     = (v.sel == 1) ? MC_B : MC_A;
        stride = v.s2 ? 2 : 1;
        if (!v.rev) begin
            for (int r = 0; r < MR; r++)
                for (int c = 0; c < mc; c += stride)
                    if (!(v.skip && r == 1 && c == 1)) begin
                        exp_r.push_back(r);
                        exp_c.push_back(c);
                    end
        end else begin
            for (int r = MR - 1; r >= 0; r--)
                for (int c = mc - 1; c >= 0; c--) begin
                    exp_r.push_back(r);
                    exp_c.push_back(c);
                end
        end
        skip_en = v.skip;
        applyStimulus(v.sel, v.rev, v.s2);
        checkOutput({v.name, " init_row_ctrl"}, int'(rctl[v.sel]), int'(v.exp_init));
        checkOutput({v.name, " init_col_ctrl"}, int'(cctl[v.sel]), int'(v.exp_init));
`ifdef SCAN_TIMEOUT_EN
        if (v.sel == 0) checkOutput({v.name, " timeout_cleared_on_start"}, int'(if_a.timeout), 0);
`endif
        idx = 0;
        last_ack = -1;
        got_done = 1'b0;
        busy_dropped = 1'b0;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            @(negedge clk);
            if (!bsy[v.sel]) busy_dropped = 1'b1;
            if (smp[v.sel] && ackv[v.sel]) begin
                if (idx < exp_r.size()) begin
                    checkOutput($sformatf("%s row[%0d]", v.name, idx), int'(rowv[v.sel]), exp_r[idx]);
                    checkOutput($sformatf("%s col[%0d]", v.name, idx), int'(colv[v.sel]), exp_c[idx]);
                end
                if (v.exp_gap != 0 && last_ack >= 0)
                    checkOutput($sformatf("%s gap[%0d]", v.name, idx), cyc - last_ack, v.exp_gap);
                last_ack = cyc;
                idx++;
            end
            if (dn[v.sel]) begin
                got_done = 1'b1;
                checkOutput({v.name, " done_latency"}, cyc - last_ack, 2);
            end
        end
        checkOutput({v.name, " done_seen"}, int'(got_done), 1);
        checkOutput({v.name, " sample_count"}, idx, v.exp_count);
        checkOutput({v.name, " busy_dropped"}, int'(busy_dropped), 0);
`ifdef SCAN_TIMEOUT_EN
        if (v.sel == 0) checkOutput({v.name, " timeout_flag"}, int'(if_a.timeout), int'(v.skip));
`endif
        @(negedge clk);
        checkOutput({v.name, " busy_after_done"}, int'(bsy[v.sel]), 0);
        checkOutput({v.name, " done_one_cycle"}, int'(dn[v.sel]), 0);
        skip_en = 1'b0;
    endtask

    initial begin
        frame_vec_t vecs[$];
        vecs.push_back('{"a_fwd",     0, 1'b0, 1'b0, 1'b0, 5'b10000, 12, 4});
        vecs.push_back('{"a_rev",     0, 1'b1, 1'b0, 1'b0, 5'b01000, 12, 4});
        vecs.push_back('{"a_stride2", 0, 1'b0, 1'b1, 1'b0, 5'b10000,  6, 4});
        vecs.push_back('{"b_fwd",     1, 1'b0, 1'b0, 1'b0, 5'b10000, 15, 2});
        vecs.push_back('{"b_stride2", 1, 1'b0, 1'b1, 1'b0, 5'b10000,  9, 2});
        vecs.push_back('{"b_rev",     1, 1'b1, 1'b0, 1'b0, 5'b01000, 15, 2});
`ifdef SCAN_TIMEOUT_EN
        vecs.push_back('{"a_timeout", 0, 1'b0, 1'b0, 1'b1, 5'b10000, 11, 0});
        vecs.push_back('{"a_post_to", 0, 1'b0, 1'b0, 1'b0, 5'b10000, 12, 4});
`endif

        rst_n     = 1'b0;
        start_v   = '0;
        abort_v   = '0;
        rev_v     = '0;
        s2_v      = '0;
        ack_en    = 2'b11;
        ack_force = '0;
        skip_en   = 1'b0;

        #12;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("reset busy[%0d]", i), int'(bsy[i]), 0);
            checkOutput($sformatf("reset sample[%0d]", i), int'(smp[i]), 0);
            checkOutput($sformatf("reset done[%0d]", i), int'(dn[i]), 0);
            checkOutput($sformatf("reset row_ctrl[%0d]", i), int'(rctl[i]), 0);
            checkOutput($sformatf("reset col_ctrl[%0d]", i), int'(cctl[i]), 0);
        end
`ifdef SCAN_TIMEOUT_EN
        checkOutput("reset timeout", int'(if_a.timeout), 0);
`endif
        rst_n = 1'b1;

        foreach (vecs[k]) run_frame(vecs[k]);

        // Abort while sampling with ack asserted in the same cycle.
        ack_en[0] = 1'b0;
        applyStimulus(0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !smp[0]; i++) @(negedge clk);
        checkOutput("abort reached_sample", int'(smp[0]), 1);
        abort_v[0]   = 1'b1;
        ack_force[0] = 1'b1;
        @(negedge clk);
        abort_v[0]   = 1'b0;
        ack_force[0] = 1'b0;
        checkOutput("abort busy", int'(bsy[0]), 0);
        checkOutput("abort sample", int'(smp[0]), 0);
        checkOutput("abort done", int'(dn[0]), 0);
        checkOutput("abort row_ctrl", int'(rctl[0]), 16);
        checkOutput("abort col_ctrl", int'(cctl[0]), 16);
        @(negedge clk);
        checkOutput("abort idle_row_ctrl", int'(rctl[0]), 0);
        checkOutput("abort no_done", int'(dn[0]), 0);
        ack_en[0] = 1'b1;

        // Asynchronous reset in the middle of SETTLE, then a clean frame.
        applyStimulus(0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midreset in_settle_busy", int'(bsy[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", int'(bsy[0]), 0);
        checkOutput("midreset sample", int'(smp[0]), 0);
        checkOutput("midreset done", int'(dn[0]), 0);
        checkOutput("midreset row_ctrl", int'(rctl[0]), 0);
        checkOutput("midreset col_ctrl", int'(cctl[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(vecs[0]);

        // start and abort together in IDLE: start wins.
        @(negedge clk);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        rev_v[0]   = 1'b0;
        s2_v[0]    = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        checkOutput("start_abort busy", int'(bsy[0]), 1);
        checkOutput("start_abort init_ctrl", int'(rctl[0]), 16);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        checkOutput("start_abort aborted", int'(bsy[0]), 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
